// File: rtl/fifo_arb_tx_if.sv
// Handshake bundle between the TX arbiter, the two client read FIFOs and the host write FIFO.
// master = arbiter side, slave = FIFO/environment side.
interface fifo_arb_tx_if #(
    parameter int DWIDTH = 8
);
    logic              c1_rden;
    logic              c1_rdempty;
    logic [DWIDTH-1:0] c1_rddata;
    logic              c2_rden;
    logic              c2_rdempty;
    logic [DWIDTH-1:0] c2_rddata;
    logic              fifo_wren;
    logic              fifo_wrfull;
    logic [DWIDTH-1:0] fifo_wrdata;
    logic              busy;
    logic [1:0]        gnt;

    modport master (
        output c1_rden, input c1_rdempty, input c1_rddata,
        output c2_rden, input c2_rdempty, input c2_rddata,
        output fifo_wren, input fifo_wrfull, output fifo_wrdata,
        output busy, output gnt
    );

    modport slave (
        input c1_rden, output c1_rdempty, output c1_rddata,
        input c2_rden, output c2_rdempty, output c2_rddata,
        input fifo_wren, output fifo_wrfull, input fifo_wrdata,
        input busy, input gnt
    );
endinterface

// File: rtl/fifo_arb_tx.sv
// Packet-aware round-robin arbiter merging two client TX FIFOs into one host FIFO.
// state | meaning:  IDLE = arbitrate | HDR = header arriving | PAY = payload reads until count exhausted
module fifo_arb_tx #(
    parameter int                DWIDTH    = 8,
    parameter logic [DWIDTH-1:0] SELMASK   = 8'h80,
    parameter int                CNT_LSB   = 4,
    parameter int                CNT_WIDTH = 3,
    parameter bit                TAG_SEL   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    fifo_arb_tx_if.master arb
);
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t                state, state_nxt;
    logic                  skid_valid, skid_valid_nxt;
    logic [DWIDTH-1:0]     skid_data, skid_data_nxt;
    logic                  data_valid;
    logic [CNT_WIDTH-1:0]  rd_left, rd_left_nxt;
    logic                  last_c2, last_c2_nxt;
    logic [1:0]            gnt, gnt_nxt;
    logic                  rden1, rden2, take, pick2;
    logic                  wren;
    logic [DWIDTH-1:0]     wrdata;
    logic                  rd_ok, gnt_empty;
    logic [DWIDTH-1:0]     rx_data, hdr_data, in_data;
    logic [CNT_WIDTH-1:0]  hdr_cnt;

    assign rd_ok     = ~arb.fifo_wrfull & ~skid_valid;
    assign rx_data   = gnt[1] ? arb.c2_rddata : arb.c1_rddata;
    assign gnt_empty = gnt[1] ? arb.c2_rdempty : arb.c1_rdempty;
    assign hdr_cnt   = rx_data[CNT_LSB +: CNT_WIDTH];

    always_comb begin
        hdr_data = rx_data;
        if (TAG_SEL)
            hdr_data = gnt[0] ? (rx_data | SELMASK) : (rx_data & ~SELMASK);
    end

    assign in_data = (state == HDR) ? hdr_data : rx_data;

    // Skid drains first; reads are blocked while it holds a byte, so it never overflows.
    always_comb begin
        wren           = 1'b0;
        wrdata         = '0;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (skid_valid) begin
            if (!arb.fifo_wrfull) begin
                wren           = 1'b1;
                wrdata         = skid_data;
                skid_valid_nxt = 1'b0;
            end
        end else if (data_valid) begin
            if (!arb.fifo_wrfull) begin
                wren   = 1'b1;
                wrdata = in_data;
            end else begin
                skid_valid_nxt = 1'b1;
                skid_data_nxt  = in_data;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_left_nxt = rd_left;
        last_c2_nxt = last_c2;
        gnt_nxt     = gnt;
        rden1       = 1'b0;
        rden2       = 1'b0;
        pick2       = 1'b0;
        take        = 1'b0;
        case (state)
            IDLE: begin
                if (rd_ok && (!arb.c1_rdempty || !arb.c2_rdempty)) begin
                    pick2       = !arb.c2_rdempty && (arb.c1_rdempty || !last_c2);
                    rden1       = !pick2;
                    rden2       = pick2;
                    gnt_nxt     = pick2 ? 2'b10 : 2'b01;
                    last_c2_nxt = pick2;
                    state_nxt   = HDR;
                end
            end
            HDR: begin
                if (hdr_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    take        = ~gnt_empty & rd_ok;
                    rd_left_nxt = hdr_cnt - CNT_WIDTH'(take);
                    state_nxt   = PAY;
                end
            end
            PAY: begin
                take        = (rd_left != '0) & ~gnt_empty & rd_ok;
                rd_left_nxt = rd_left - CNT_WIDTH'(take);
                if (rd_left == '0 && !data_valid && !skid_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            rden1 = take & gnt[0];
            rden2 = take & gnt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            data_valid <= 1'b0;
            rd_left    <= '0;
            last_c2    <= 1'b1;
            gnt        <= 2'b00;
        end else begin
            state      <= state_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            data_valid <= rden1 | rden2;
            rd_left    <= rd_left_nxt;
            last_c2    <= last_c2_nxt;
            gnt        <= gnt_nxt;
        end
    end

    // Strobes are combinational, so they are forced low for the whole reset pulse.
    assign arb.c1_rden     = rden1 & ~rst;
    assign arb.c2_rden     = rden2 & ~rst;
    assign arb.fifo_wren   = wren & ~rst;
    assign arb.fifo_wrdata = rst ? '0 : wrdata;
    assign arb.busy        = (state != IDLE) | skid_valid;
    assign arb.gnt         = gnt;
endmodule

// File: tb/tb_fifo_arb_tx.sv
// Scoreboard bench for fifo_arb_tx: client FIFO models feed the arbiter, a monitor checks every host write.
module tb_fifo_arb_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fifo_arb_tx_if #(.DWIDTH(8)) bus ();
    fifo_arb_tx_if #(.DWIDTH(8)) bus_b ();

    fifo_arb_tx #(.TAG_SEL(1'b1)) dut_a (.clk(clk), .rst(rst), .arb(bus.master));
    fifo_arb_tx #(.TAG_SEL(1'b0)) dut_b (.clk(clk), .rst(rst), .arb(bus_b.master));

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q2b[$];
    logic [7:0] obs_b[$];
    logic [9:0] exp_q[$];
    int push1 = 0, pop1 = 0, push2 = 0, pop2 = 0, push2b = 0, pop2b = 0;

    assign bus.c1_rdempty   = (push1 == pop1);
    assign bus.c2_rdempty   = (push2 == pop2);
    assign bus_b.c1_rdempty = 1'b1;
    assign bus_b.c1_rddata  = 8'h00;
    assign bus_b.c2_rdempty = (push2b == pop2b);

    // Client FIFO models: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.c1_rden) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL c1_rden_empty: read strobe while client 1 FIFO empty");
            end else begin
                bus.c1_rddata <= q1.pop_front();
                pop1 <= pop1 + 1;
            end
        end
        if (bus.c2_rden) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL c2_rden_empty: read strobe while client 2 FIFO empty");
            end else begin
                bus.c2_rddata <= q2.pop_front();
                pop2 <= pop2 + 1;
            end
        end
        if (bus_b.c2_rden && q2b.size() != 0) begin
            bus_b.c2_rddata <= q2b.pop_front();
            pop2b <= pop2b + 1;
        end
    end

    // Monitor: samples mid-low-phase, after all stimulus for the cycle has settled.
    always @(negedge clk) begin
        logic [9:0] e;
        #2;
        if ((bus.c1_rden || bus.c2_rden) && bus.fifo_wrfull) begin
            tests++; fails++;
            $display("FAIL rden_while_full: rden=%b%b with fifo_wrfull=1", bus.c2_rden, bus.c1_rden);
        end
        if (bus.c1_rden && bus.c2_rden) begin
            tests++; fails++;
            $display("FAIL rden_both: both client read strobes high");
        end
        if (bus.fifo_wren) begin
            tests++;
            if (bus.fifo_wrfull) begin
                fails++;
                $display("FAIL wren_while_full: data %02h written while full", bus.fifo_wrdata);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got data %02h gnt %b, nothing expected", bus.fifo_wrdata, bus.gnt);
            end else begin
                e = exp_q.pop_front();
                if ({bus.gnt, bus.fifo_wrdata} !== e) begin
                    fails++;
                    $display("FAIL write_data: got data %02h gnt %b, expected data %02h gnt %b",
                             bus.fifo_wrdata, bus.gnt, e[7:0], e[9:8]);
                end
            end
        end
        if (bus_b.fifo_wren) obs_b.push_back(bus_b.fifo_wrdata);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic c1_push(input logic [7:0] d);
        q1.push_back(d);
        push1 = push1 + 1;
    endtask

    task automatic c2_push(input logic [7:0] d);
        q2.push_back(d);
        push2 = push2 + 1;
    endtask

    task automatic exp_push(input logic [7:0] d, input logic [1:0] g);
        exp_q.push_back({g, d});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.busy == 1'b0 && exp_q.size() == 0 && q1.size() == 0 && q2.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL %s_timeout: busy=%b pending=%0d, expected idle with all bytes written",
                     name, bus.busy, exp_q.size());
        end
    endtask

    initial begin
        bus.fifo_wrfull   = 1'b0;
        bus_b.fifo_wrfull = 1'b0;
        #1;
        check("rst_c1_rden", {31'd0, bus.c1_rden}, 0);
        check("rst_c2_rden", {31'd0, bus.c2_rden}, 0);
        check("rst_wren", {31'd0, bus.fifo_wren}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_gnt", {30'd0, bus.gnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single client-1 packet, cnt=2, header tagged with 0x80
        c1_push(8'h20); c1_push(8'hAA); c1_push(8'hBB);
        exp_push(8'hA0, 2'b01); exp_push(8'hAA, 2'b01); exp_push(8'hBB, 2'b01);
        q2b.push_back(8'h90); q2b.push_back(8'h55); push2b = push2b + 2;
        #1 check("t1_rden_c0", {31'd0, bus.c1_rden}, 1);
        @(negedge clk); #1 check("t1_rden_c1", {31'd0, bus.c1_rden}, 1);
        @(negedge clk); #1 check("t1_rden_c2", {31'd0, bus.c1_rden}, 1);
        @(negedge clk); #1 check("t1_rden_c3", {31'd0, bus.c1_rden}, 0);
        wait_idle("t1");
        check("t1_gnt", {30'd0, bus.gnt}, 32'h1);

        // client-2 packet: select bit cleared
        c2_push(8'h90); c2_push(8'h55);
        exp_push(8'h10, 2'b10); exp_push(8'h55, 2'b10);
        wait_idle("t2");
        check("t2_gnt", {30'd0, bus.gnt}, 32'h2);

        // both preloaded with two packets each: strict alternation starting at c1
        c1_push(8'h10); c1_push(8'h11); c1_push(8'h10); c1_push(8'h12);
        c2_push(8'h10); c2_push(8'h21); c2_push(8'h10); c2_push(8'h22);
        exp_push(8'h90, 2'b01); exp_push(8'h11, 2'b01);
        exp_push(8'h10, 2'b10); exp_push(8'h21, 2'b10);
        exp_push(8'h90, 2'b01); exp_push(8'h12, 2'b01);
        exp_push(8'h10, 2'b10); exp_push(8'h22, 2'b10);
        wait_idle("t3");

        // output full the cycle after the first payload read, for 3 cycles
        c1_push(8'h20); c1_push(8'h33); c1_push(8'h44);
        exp_push(8'hA0, 2'b01); exp_push(8'h33, 2'b01); exp_push(8'h44, 2'b01);
        @(negedge clk);
        @(negedge clk);
        bus.fifo_wrfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_no_rden_full", {31'd0, bus.c1_rden}, 0);
            check("t4_busy_full", {31'd0, bus.busy}, 1);
            @(negedge clk);
        end
        bus.fifo_wrfull = 1'b0;
        #1;
        check("t4_skid_wren", {31'd0, bus.fifo_wren}, 1);
        check("t4_skid_data", {24'd0, bus.fifo_wrdata}, 32'h33);
        check("t4_no_rden_skid", {31'd0, bus.c1_rden}, 0);
        wait_idle("t4");

        // client 1 starves mid-packet: grant held, client 2 waits
        c1_push(8'h30); c1_push(8'h01);
        exp_push(8'hB0, 2'b01); exp_push(8'h01, 2'b01); exp_push(8'h02, 2'b01); exp_push(8'h03, 2'b01);
        exp_push(8'h10, 2'b10); exp_push(8'h77, 2'b10);
        @(negedge clk);
        c2_push(8'h10); c2_push(8'h77);
        for (int i = 0; i < 5; i++) begin
            #1 check("t5_c2_blocked", {31'd0, bus.c2_rden}, 0);
            @(negedge clk);
        end
        c1_push(8'h02); c1_push(8'h03);
        wait_idle("t5");

        // reset mid-payload with two bytes still to read
        c1_push(8'h30); c1_push(8'h01); c1_push(8'h02); c1_push(8'h03);
        exp_push(8'hB0, 2'b01); exp_push(8'h01, 2'b01);
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_c1_rden", {31'd0, bus.c1_rden}, 0);
        check("t6_rst_wren", {31'd0, bus.fifo_wren}, 0);
        check("t6_rst_busy", {31'd0, bus.busy}, 0);
        check("t6_rst_gnt", {30'd0, bus.gnt}, 0);
        check("t6_rst_wrdata", {24'd0, bus.fifo_wrdata}, 0);
        check("t6_left_in_fifo", q1.size(), 2);
        push1 = push1 - q1.size();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        c1_push(8'h00); c2_push(8'h00);
        exp_push(8'h80, 2'b01); exp_push(8'h00, 2'b10);
        wait_idle("t6");

        // back-to-back zero-length packets: write, idle, write, idle, write
        c1_push(8'h00); c1_push(8'h00); c1_push(8'h00);
        exp_push(8'h80, 2'b01); exp_push(8'h80, 2'b01); exp_push(8'h80, 2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t7_wren_pattern", {31'd0, bus.fifo_wren}, (i % 2 == 0) ? 1 : 0);
            check("t7_busy_pattern", {31'd0, bus.busy}, (i % 2 == 0) ? 1 : 0);
        end
        wait_idle("t7");

        // untagged instance passed its client-2 header through unchanged
        check("tb0_count", obs_b.size(), 2);
        if (obs_b.size() == 2) begin
            check("tb0_hdr", {24'd0, obs_b[0]}, 32'h90);
            check("tb0_pay", {24'd0, obs_b[1]}, 32'h55);
        end
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule
